// File: rtl/preprocess_pkg.sv
// Purpose: constants and FSM encoding shared by the preprocessing blocks
//          (gaussian, frame_writer, frame_reader).
// Ports:   none (package).
package preprocess_pkg;

   localparam int IMG_WIDTH_DEF  = 220;
   localparam int IMG_HEIGHT_DEF = 168;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } fw_state_e;

endpackage

// File: rtl/frame_writer.sv
// Purpose: captures one filtered frame into one half of a double-buffered BRAM
//          and hands the finished half to the reader when the geometry was clean.
// Latency: one cycle from an accepted pixel to its write; frame_done two cycles
//          after the frame_end pixel.
// Backpressure: none; pixels outside an armed capture are dropped.
// Ports:   clk/rst (sync, active-high); start, pixel_in/pixel_valid/line_end/
//          frame_end in; wr_en/wr_addr/wr_data BRAM write port; rd_base,
//          frame_done, busy, frame_err status out.
module frame_writer
   import preprocess_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pixel_in,
   input  logic                  pixel_valid,
   input  logic                  line_end,
   input  logic                  frame_end,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [ADDR_WIDTH-1:0] rd_base,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int COL_W = $clog2(IMG_WIDTH + 1);
   localparam logic [ADDR_WIDTH-1:0] FRAME_PIX = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_WIDTH);
   localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);

   fw_state_e             state_q, state_d;
   logic [COL_W-1:0]      col_q, col_d;
   // Linear offset of column 0 of the current row (row*IMG_WIDTH), stepped
   // by IMG_WIDTH on each line wrap so no multiplier is needed.
   logic [ADDR_WIDTH-1:0] line_q, line_d;
   logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
   logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
   logic                  err_q, err_d;
   // Set by the frame_end pixel; holds WRITE for one more cycle so that
   // frame_done follows the final write rather than coinciding with it.
   logic                  last_q, last_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic [ADDR_WIDTH-1:0] offset;
   logic                  col_last;
   logic                  accept;

   assign offset   = line_q + ADDR_WIDTH'(col_q);
   assign col_last = (col_q == LAST_COL);
   assign accept   = (state_q == ST_WRITE) && pixel_valid && !last_q;

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      line_d     = line_q;
      wr_base_d  = wr_base_q;
      rd_base_d  = rd_base_q;
      err_d      = err_q;
      last_d     = last_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      frame_done = 1'b0;
      busy       = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_WRITE;
               col_d     = '0;
               line_d    = '0;
               err_d     = 1'b0;
               last_d    = 1'b0;
               wr_base_d = (rd_base_q == '0) ? FRAME_PIX : '0;
            end
         end

         ST_WRITE: begin
            if (last_q) begin
               // rd_base switches on entry to DONE so that it is already
               // valid during the frame_done cycle.
               state_d = ST_DONE;
               if (!err_q) rd_base_d = wr_base_q;
            end else if (accept) begin
               if (offset < FRAME_PIX) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = wr_base_q + offset;
                  wr_data_d = pixel_in;
               end else begin
                  err_d = 1'b1;
               end
               // line_end must coincide exactly with the last column.
               if (line_end != col_last) err_d = 1'b1;
               if (frame_end) begin
                  last_d = 1'b1;
                  if ((offset != FRAME_PIX - 1'b1) || !line_end) err_d = 1'b1;
               end
               if (line_end || col_last) begin
                  col_d = '0;
                  // Saturate once past the frame so the offset cannot wrap
                  // back into range on a runaway stream.
                  if (line_q < FRAME_PIX) line_d = line_q + LINE_STEP;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            frame_done = 1'b1;
            last_d     = 1'b0;
            state_d    = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         line_q    <= '0;
         wr_base_q <= '0;
         rd_base_q <= FRAME_PIX;
         err_q     <= 1'b0;
         last_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         line_q    <= line_d;
         wr_base_q <= wr_base_d;
         rd_base_q <= rd_base_d;
         err_q     <= err_d;
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_base   = rd_base_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Purpose: directed self-checking bench for frame_writer on a 4x3 frame.
// Ports:   none (top-level bench).
module tb_frame_writer;

   localparam int AW = 17;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] pixel_in;
   logic          pixel_valid;
   logic          line_end;
   logic          frame_end;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_base;
   logic          frame_done;
   logic          busy;
   logic          frame_err;

   frame_writer #(
      .IMG_WIDTH (4),
      .IMG_HEIGHT(3),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pixel_in   (pixel_in),
      .pixel_valid(pixel_valid),
      .line_end   (line_end),
      .frame_end  (frame_end),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_base    (rd_base),
      .frame_done (frame_done),
      .busy       (busy),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            last_pix_cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   logic          done_err = 1'b0;
   logic [AW-1:0] done_rd = '0;
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];

   // Write and frame_done monitor, sampled just after each rising edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (wr_en) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         done_err = frame_err;
         done_rd  = rd_base;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Pixel i carries data 0x10+i; line_end from the mask, frame_end at fe_idx,
   // and an optional start pulse alongside pixel start_at.
   task automatic send(input int n, input logic [15:0] le_mask, input int fe_idx,
                       input int start_at);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pixel_valid  = 1'b1;
         pixel_in     = DW'(16 + i);
         line_end     = le_mask[i];
         frame_end    = (i == fe_idx);
         start        = (i == start_at);
         last_pix_cyc = cyc;
      end
      @(negedge clk);
      pixel_valid = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;
      start       = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      checks++;
      if ({wr_en, wr_addr, wr_data, frame_done, busy, frame_err} !== '0) begin
         failures++;
         $display("FAIL reset_outs: got en=%b addr=%0d data=%0h done=%b busy=%b err=%b want all 0",
                  wr_en, wr_addr, wr_data, frame_done, busy, frame_err);
      end
      checks++;
      if (rd_base !== AW'(12)) begin
         failures++;
         $display("FAIL reset_rd_base: got %0d want 12", rd_base);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_clean_frame(input logic [AW-1:0] base);
      int n0;
      int d0;
      n0 = wa_q.size();
      d0 = done_cnt;
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL clean_busy: got %b want 1", busy);
      end
      send(12, 16'h0888, 11, -1);
      idle(4);
      checks++;
      if (wa_q.size() - n0 != 12) begin
         failures++;
         $display("FAIL clean_count base=%0d: got %0d writes want 12", base, wa_q.size() - n0);
      end
      for (int i = 0; i < 12; i++) begin
         if (n0 + i < wa_q.size()) begin
            checks++;
            if ({wa_q[n0+i], wd_q[n0+i]} !== {base + AW'(i), DW'(16 + i)}) begin
               failures++;
               $display("FAIL clean_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                        i, wa_q[n0+i], wd_q[n0+i], base + AW'(i), 16 + i);
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || done_cyc - last_pix_cyc != 2) begin
         failures++;
         $display("FAIL clean_done: got pulses=%0d delay=%0d want pulses=1 delay=2",
                  done_cnt - d0, done_cyc - last_pix_cyc);
      end
      checks++;
      if ({done_err, done_rd} !== {1'b0, base} || rd_base !== base) begin
         failures++;
         $display("FAIL clean_status: got err=%b rd@done=%0d rd=%0d want err=0 rd=%0d",
                  done_err, done_rd, rd_base, base);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL clean_idle_busy: got %b want 0", busy);
      end
   endtask

   // line_end on pixel 2 of line 0: writes land at 0,1,2 then 4..11 of half 12.
   task automatic test_line_end_err();
      int n0;
      logic [AW-1:0] ea;
      n0 = wa_q.size();
      pulse_start();
      send(11, 16'h0444, 10, -1);
      idle(4);
      checks++;
      if (wa_q.size() - n0 != 11) begin
         failures++;
         $display("FAIL le_count: got %0d writes want 11", wa_q.size() - n0);
      end
      for (int i = 0; i < 11; i++) begin
         ea = AW'(12 + ((i < 3) ? i : i + 1));
         if (n0 + i < wa_q.size()) begin
            checks++;
            if ({wa_q[n0+i], wd_q[n0+i]} !== {ea, DW'(16 + i)}) begin
               failures++;
               $display("FAIL le_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                        i, wa_q[n0+i], wd_q[n0+i], ea, 16 + i);
            end
         end
      end
      checks++;
      if ({done_err, done_rd, frame_err, rd_base} !== {1'b1, AW'(0), 1'b1, AW'(0)}) begin
         failures++;
         $display("FAIL le_status: got err@done=%b rd@done=%0d err=%b rd=%0d want 1,0,1,0",
                  done_err, done_rd, frame_err, rd_base);
      end
   endtask

   // 14 pixels: offsets 12 and 13 overflow the frame and must not be written.
   task automatic test_overrun();
      int n0;
      n0 = wa_q.size();
      pulse_start();
      send(14, 16'h0888, 13, -1);
      idle(4);
      checks++;
      if (wa_q.size() - n0 != 12) begin
         failures++;
         $display("FAIL ovr_count: got %0d writes want 12", wa_q.size() - n0);
      end
      for (int i = 0; i < 12; i++) begin
         if (n0 + i < wa_q.size()) begin
            checks++;
            if (wa_q[n0+i] !== AW'(12 + i)) begin
               failures++;
               $display("FAIL ovr_addr[%0d]: got %0d want %0d", i, wa_q[n0+i], 12 + i);
            end
         end
      end
      checks++;
      if ({done_err, rd_base} !== {1'b1, AW'(0)}) begin
         failures++;
         $display("FAIL ovr_status: got err=%b rd=%0d want err=1 rd=0", done_err, rd_base);
      end
   endtask

   task automatic test_prestart_midstart();
      int n0;
      int d0;
      n0 = wa_q.size();
      d0 = done_cnt;
      send(3, 16'h0004, 2, -1);
      idle(2);
      checks++;
      if (wa_q.size() != n0 || busy !== 1'b0 || done_cnt != d0) begin
         failures++;
         $display("FAIL prestart_drop: got writes=%0d busy=%b dones=%0d want 0,0,0",
                  wa_q.size() - n0, busy, done_cnt - d0);
      end
      // Pixel coincident with start must be dropped.
      @(negedge clk);
      start       = 1'b1;
      pixel_valid = 1'b1;
      pixel_in    = 8'hAA;
      @(negedge clk);
      start       = 1'b0;
      pixel_valid = 1'b0;
      send(12, 16'h0888, 11, 5);
      idle(4);
      checks++;
      if (wa_q.size() - n0 != 12) begin
         failures++;
         $display("FAIL midstart_count: got %0d writes want 12", wa_q.size() - n0);
      end
      for (int i = 0; i < 12; i++) begin
         if (n0 + i < wa_q.size()) begin
            checks++;
            if ({wa_q[n0+i], wd_q[n0+i]} !== {AW'(12 + i), DW'(16 + i)}) begin
               failures++;
               $display("FAIL midstart_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                        i, wa_q[n0+i], wd_q[n0+i], 12 + i, 16 + i);
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1 || {done_err, rd_base} !== {1'b0, AW'(12)}) begin
         failures++;
         $display("FAIL midstart_status: got dones=%0d err=%b rd=%0d want 1,0,12",
                  done_cnt - d0, done_err, rd_base);
      end
   endtask

   task automatic test_reset_midframe();
      int n0;
      int d0;
      n0 = wa_q.size();
      d0 = done_cnt;
      pulse_start();
      send(5, 16'h0008, -1, -1);
      checks++;
      if (wa_q.size() - n0 != 5 || (wa_q.size() > n0 && wa_q[n0] !== AW'(0))) begin
         failures++;
         $display("FAIL midrst_pre: got writes=%0d want 5 starting at 0", wa_q.size() - n0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_data, frame_done, busy, frame_err} !== '0 || rd_base !== AW'(12)) begin
         failures++;
         $display("FAIL midrst_outs: got en=%b addr=%0d data=%0h done=%b busy=%b err=%b rd=%0d want 0s rd=12",
                  wr_en, wr_addr, wr_data, frame_done, busy, frame_err, rd_base);
      end
      rst = 1'b0;
      idle(6);
      checks++;
      if (done_cnt != d0) begin
         failures++;
         $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      pixel_in    = '0;
      pixel_valid = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;
      test_reset();
      test_clean_frame(AW'(0));
      test_clean_frame(AW'(12));
      test_clean_frame(AW'(0));
      test_line_end_err();
      test_overrun();
      test_prestart_midstart();
      test_reset_midframe();
      test_clean_frame(AW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
